lfsr_stream_cipher: RTL and testbench

- Parametrised LFSR stream-cipher engine, successor to the fixed 8-bit-data / 6-bit-key encryptor.
- A key is loaded into a Fibonacci LFSR, which is optionally warmed up.
- Each accepted data word is then XORed with a freshly generated DATA_W-bit keystream word, one keystream bit per clock.
- Valid/ready handshakes on both sides let it sit between a data source and a sink in the lab datapath. Encryption and decryption are the same operation.

---
 rtl/lfsr_stream_cipher.sv | 152 +++++++++++++++
 tb/tb_lfsr_stream_cipher.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_cipher.sv
// LFSR stream cipher: a Fibonacci LFSR seeded by a key generates one keystream bit per clock,
// and each accepted data word is XORed with the next DATA_W keystream bits.
module lfsr_stream_cipher #(
    parameter int unsigned      DATA_W = 8,
    parameter int unsigned      KEY_W  = 6,
    parameter logic [KEY_W-1:0] TAPS   = 6'b110000,
    parameter int unsigned      WARMUP = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [KEY_W-1:0]  key,
    input  logic [DATA_W-1:0] datain,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] dataout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ready
);

    localparam int unsigned CntMax = (WARMUP > DATA_W) ? WARMUP : DATA_W;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] GenLast  = CntW'(DATA_W - 1);
    localparam logic [CntW-1:0] WarmLast = (WARMUP > 0) ? CntW'(WARMUP - 1) : '0;

    typedef enum logic [2:0] {
        StIdle,
        StWarm,
        StRdy,
        StGen,
        StOut
    } state_e;

    state_e state_q, state_d;

    logic [KEY_W-1:0]  lfsr_q, lfsr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] ks_q, ks_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] dataout_q, dataout_d;
    logic              out_valid_q, out_valid_d;

    logic              fb;
    logic              shift_en;
    logic [DATA_W-1:0] ks_full;

    assign fb = ^(lfsr_q & TAPS);
    // Keystream including the bit generated on this edge; first bit lands in the MSB.
    assign ks_full = {ks_q[DATA_W-2:0], fb};
    // The LFSR is frozen outside WARM/GEN, which keeps the keystream continuous across words.
    assign shift_en = !load && ((state_q == StWarm) || (state_q == StGen));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load overrides everything
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (WARMUP > 0) ? StWarm : StRdy;
        end else begin
            unique case (state_q)
                StIdle: state_d = StIdle;
                StWarm: if (cnt_q == WarmLast) state_d = StRdy;
                StRdy:  if (in_valid) state_d = StGen;
                StGen:  if (cnt_q == GenLast) state_d = StOut;
                StOut:  if (out_ready) state_d = StRdy;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q      <= '0;
            cnt_q       <= '0;
            ks_q        <= '0;
            data_q      <= '0;
            dataout_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            ks_q        <= ks_d;
            data_q      <= data_d;
            dataout_q   <= dataout_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        ks_d        = ks_q;
        data_d      = data_q;
        dataout_d   = dataout_q;
        out_valid_d = out_valid_q;

        if (load) begin
            // An all-zero seed would lock the LFSR at zero forever.
            lfsr_d      = (key == '0) ? KEY_W'(1) : key;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (shift_en) begin
                lfsr_d = {lfsr_q[KEY_W-2:0], fb};
                cnt_d  = cnt_q + CntW'(1);
            end
            unique case (state_q)
                StRdy: begin
                    if (in_valid) begin
                        data_d = datain;
                        ks_d   = '0;
                        cnt_d  = '0;
                    end
                end
                StGen: begin
                    ks_d = ks_full;
                    if (cnt_q == GenLast) begin
                        dataout_d   = data_q ^ ks_full;
                        out_valid_d = 1'b1;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StRdy);
        ready     = (state_q == StRdy) || (state_q == StGen) || (state_q == StOut);
        dataout   = dataout_q;
        out_valid = out_valid_q;
    end

endmodule

// File: tb/tb_lfsr_stream_cipher.sv
// Self-checking bench for lfsr_stream_cipher: directed known-answer tests plus random traffic
// compared every cycle against a transaction-level keystream model.
module tb_lfsr_stream_cipher;

    localparam int DW = 8;
    localparam int KW = 6;
    localparam int Taps = 6'b110000;
    localparam int Mask = (1 << KW) - 1;

    localparam int PIdle = 0;
    localparam int PWarm = 1;
    localparam int PRdy  = 2;
    localparam int PGen  = 3;
    localparam int POut  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load, in_valid, out_ready;
    logic [KW-1:0] key;
    logic [DW-1:0] datain;
    logic          in_ready, out_valid, ready;
    logic [DW-1:0] dataout;

    logic          w_load, w_in_valid, w_out_ready;
    logic [KW-1:0] w_key;
    logic [DW-1:0] w_datain;
    logic          w_in_ready, w_out_valid, w_ready;
    logic [DW-1:0] w_dataout;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    lfsr_stream_cipher u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .key       (key),
        .datain    (datain),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ready     (ready)
    );

    lfsr_stream_cipher #(
        .WARMUP (8)
    ) u_warm (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .key       (w_key),
        .datain    (w_datain),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .dataout   (w_dataout),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .ready     (w_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Keystream generator rule in plain integer arithmetic: state doubles, parity bit enters.
    function automatic int step(input int s);
        int b;
        b = $countones(s & Taps) % 2;
        return ((s * 2) + b) & Mask;
    endfunction

    function automatic int advance(input int s, input int n);
        int t = s;
        for (int i = 0; i < n; i++) t = step(t);
        return t;
    endfunction

    function automatic int ks_word(input int s);
        int t = s;
        int w = 0;
        for (int i = 0; i < DW; i++) begin
            w = (w * 2) + ($countones(t & Taps) % 2);
            t = step(t);
        end
        return w & ((1 << DW) - 1);
    endfunction

    // Transaction-level model of the default-parameter instance (WARMUP = 0)
    int m_ph, m_left, m_lfsr, m_word, m_dout;
    bit m_ov;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= PIdle;
            m_lfsr <= 0;
            m_dout <= 0;
            m_ov   <= 1'b0;
            m_left <= 0;
            m_word <= 0;
        end else if (load) begin
            m_lfsr <= (key == 0) ? 1 : int'(key);
            m_ov   <= 1'b0;
            m_ph   <= PRdy;
        end else begin
            case (m_ph)
                PRdy: if (in_valid) begin
                    m_word <= int'(datain) ^ ks_word(m_lfsr);
                    m_left <= DW;
                    m_ph   <= PGen;
                end
                PGen: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_dout <= m_word;
                        m_ov   <= 1'b1;
                        m_lfsr <= advance(m_lfsr, DW);
                        m_ph   <= POut;
                    end
                end
                POut: if (out_ready) begin
                    m_ov <= 1'b0;
                    m_ph <= PRdy;
                end
                default: begin
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dataout", dataout, m_dout);
            chk("out_valid", out_valid, m_ov);
            chk("in_ready", in_ready, m_ph == PRdy);
            chk("ready", ready, (m_ph == PRdy) || (m_ph == PGen) || (m_ph == POut));
            if (m_ph != PGen) chk("lfsr", u_dut.lfsr_q, m_lfsr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_key(input int k);
        load = 1'b1;
        key  = KW'(k);
        tick();
        load = 1'b0;
    endtask

    // Send one word; if out_ready is high the output handshake edge is consumed too.
    task automatic send(input int d, output int res, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("accept_wait", in_ready, 1);
        in_valid = 1'b1;
        datain   = DW'(d);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("output_wait", out_valid, 1);
        res = int'(dataout);
        if (out_ready) tick();
    endtask

    initial begin
        int r, l, c1, c2, hold, n;
        rst_n = 1'b0;
        {load, in_valid, out_ready, key, datain} = '0;
        {w_load, w_in_valid, w_key, w_datain} = '0;
        w_out_ready = 1'b1;

        @(posedge clk);
        #2;
        chk("rst_dataout", dataout, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ready", ready, 0);
        chk("rst_lfsr", u_dut.lfsr_q, 0);
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        // Basic known answers, key = 1
        load_key(1);
        chk("ready_after_load", ready, 1);
        send(8'hAA, r, l);
        chk("basic_word1", r, 8'hA6);
        chk("basic_latency", l, DW);
        send(8'hAA, r, l);
        chk("basic_word2", r, 8'hF9);
        chk("basic_lfsr_after", u_dut.lfsr_q, 6'b010011);

        // Zero-key guard
        load_key(0);
        chk("zero_key_lfsr", u_dut.lfsr_q, 1);
        send(8'hAA, r, l);
        chk("zero_key_word", r, 8'hA6);

        // Round trip
        load_key(6'b010100);
        send(8'h3C, c1, l);
        send(8'hC3, c2, l);
        load_key(6'b010100);
        send(c1, r, l);
        chk("roundtrip_1", r, 8'h3C);
        send(c2, r, l);
        chk("roundtrip_2", r, 8'hC3);

        // Backpressure, then abort by load while in OUT
        out_ready = 1'b0;
        load_key(5);
        send(8'h5A, hold, l);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_dataout_stable", dataout, hold);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid_high", out_valid, 1);
        end
        load_key(6'h2D);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_lfsr", u_dut.lfsr_q, 6'h2D);
        out_ready = 1'b1;

        // Async reset in the middle of GEN
        load_key(1);
        in_valid = 1'b1;
        datain   = 8'hAA;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dataout", dataout, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_ready", ready, 0);
        chk("arst_lfsr", u_dut.lfsr_q, 0);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        datain   = 8'h55;
        repeat (5) tick();
        chk("idle_ignores_in_valid", in_ready, 0);
        chk("idle_not_ready", ready, 0);
        in_valid = 1'b0;
        load_key(1);
        send(8'hAA, r, l);
        chk("post_reset_word", r, 8'hA6);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            load      = ($urandom % 60) == 0;
            key       = KW'($urandom);
            in_valid  = $urandom % 2;
            datain    = DW'($urandom);
            out_ready = ($urandom % 4) != 0;
            tick();
        end
        {load, in_valid} = '0;
        out_ready = 1'b1;
        repeat (20) tick();

        // Warm-up instance
        w_load = 1'b1;
        w_key  = 6'd1;
        tick();
        w_load = 1'b0;
        n = 0;
        while (!w_ready && n < 30) begin
            tick();
            n++;
        end
        chk("warm_ready_edges", n, 8);
        chk("warm_in_ready", w_in_ready, 1);
        w_in_valid = 1'b1;
        w_datain   = 8'hAA;
        tick();
        w_in_valid = 1'b0;
        n = 0;
        while (!w_out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("warm_latency", n, DW);
        chk("warm_word", w_dataout, 8'hF9);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
